// File: rtl/approx_err_monitor_pkg.sv
// Shared types, default widths and the exact abs-diff reference function for the
// approximate abs-diff evaluators.
package approx_eval_pkg;

  localparam int DEF_IN_W    = 4;
  localparam int DEF_OUT_W   = 2;
  localparam int DEF_DUT_LAT = 0;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // |A-B| at IN_W/2+1 bits, truncated to the DUT output width
  function automatic logic [DEF_OUT_W-1:0] abs_diff_exact(input logic [DEF_IN_W-1:0] vec);
    logic [DEF_IN_W/2:0] a;
    logic [DEF_IN_W/2:0] b;
    logic [DEF_IN_W/2:0] d;
    a = {1'b0, vec[DEF_IN_W-1:DEF_IN_W/2]};
    b = {1'b0, vec[DEF_IN_W/2-1:0]};
    d = (a >= b) ? (a - b) : (b - a);
    return DEF_OUT_W'(d);
  endfunction

endpackage

// File: rtl/approx_err_monitor_abs_diff_ref.sv
// abs_diff_ref: combinational exact |A-B| golden model, A = upper half of vec,
// B = lower half, result truncated to OUT_W bits.
module abs_diff_ref
  import approx_eval_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  vec,
  output logic [OUT_W-1:0] exact
);

  localparam int H = IN_W / 2;

  logic [H:0] a;
  logic [H:0] b;
  logic [H:0] d;

  always_comb begin
    a     = {1'b0, vec[IN_W-1:H]};
    b     = {1'b0, vec[H-1:0]};
    d     = (a >= b) ? (a - b) : (b - a);
    exact = OUT_W'(d);
  end

endmodule

// File: rtl/approx_err_monitor.sv
// approx_err_monitor: sweeps every input vector through an approximate abs-diff DUT and
// scores it against the exact result. Define APPROX_ERR_TRACE_EN for first-failure trace ports.
// state | meaning
// IDLE  | waiting for start, dut_in parked at 0
// SWEEP | driving vectors 0..2^IN_W-1, one per cycle
// DRAIN | DUT_LAT+1 cycles until the last response is accumulated
// DONE  | one-cycle done pulse, results final
module approx_err_monitor
  import approx_eval_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int DUT_LAT = DEF_DUT_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OUT_W-1:0] et,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] max_err,
  output logic [CNT_W-1:0] err_cnt,
`ifdef APPROX_ERR_TRACE_EN
  output logic             first_fail_vld,
  output logic [IN_W-1:0]  first_fail_vec,
  output logic [OUT_W-1:0] first_fail_out,
`endif
  output logic [CNT_W-1:0] err_sum
);

  localparam int DRN_W = $clog2(DUT_LAT + 2);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    dut_in_q, dut_in_d;
  logic [OUT_W-1:0]   et_q, et_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               pass_q, pass_d;
  logic [OUT_W-1:0]   max_q, max_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   sum_q, sum_d;
  logic [OUT_W-1:0]   err_q, err_d;
  logic               err_vld_q, err_vld_d;
  logic [CNT_W:0]     sum_ext;
  logic [IN_W-1:0]    dly_vec;
  logic               dly_vld;
  logic [OUT_W-1:0]   exact;
  logic               sweep_vld;
  logic               accept;

  assign sweep_vld = (state_q == SWEEP);
  assign accept    = (state_q == IDLE) && start;

  // Delay line aligning each driven vector with the DUT response it produces
  generate
    if (DUT_LAT == 0) begin : g_no_dly
      assign dly_vec = dut_in_q;
      assign dly_vld = sweep_vld;
    end else begin : g_dly
      logic [DUT_LAT-1:0][IN_W-1:0] sr_vec_q, sr_vec_d;
      logic [DUT_LAT-1:0]           sr_vld_q, sr_vld_d;

      always_comb begin
        sr_vec_d    = sr_vec_q;
        sr_vld_d    = sr_vld_q;
        sr_vec_d[0] = dut_in_q;
        sr_vld_d[0] = sweep_vld;
        for (int i = 1; i < DUT_LAT; i++) begin
          sr_vec_d[i] = sr_vec_q[i-1];
          sr_vld_d[i] = sr_vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sr_vec_q <= '0;
          sr_vld_q <= '0;
        end else begin
          sr_vec_q <= sr_vec_d;
          sr_vld_q <= sr_vld_d;
        end
      end

      assign dly_vec = sr_vec_q[DUT_LAT-1];
      assign dly_vld = sr_vld_q[DUT_LAT-1];
    end
  endgenerate

  abs_diff_ref #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ref (
    .vec   (dly_vec),
    .exact (exact)
  );

  always_comb begin
    err_d     = (exact >= dut_out) ? (exact - dut_out) : (dut_out - exact);
    err_vld_d = dly_vld;
  end

  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    drn_d    = drn_q;
    case (state_q)
      IDLE: begin
        dut_in_d = '0;
        if (start) state_d = SWEEP;
      end
      SWEEP: begin
        if (dut_in_q == {IN_W{1'b1}}) begin
          state_d = DRAIN;
          drn_d   = DRN_W'(DUT_LAT);
        end else begin
          dut_in_d = dut_in_q + IN_W'(1);
        end
      end
      DRAIN: begin
        if (drn_q == '0) state_d = DONE;
        else             drn_d   = drn_q - DRN_W'(1);
      end
      DONE: begin
        state_d  = IDLE;
        dut_in_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    et_d    = et_q;
    pass_d  = pass_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sum_ext = {1'b0, sum_q} + (CNT_W+1)'(err_q);
    if (accept) begin
      et_d   = et;
      pass_d = 1'b0;
      max_d  = '0;
      cnt_d  = '0;
      sum_d  = '0;
    end else if (err_vld_q) begin
      if (err_q > max_q) max_d = err_q;
      if ((err_q != '0) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
      sum_d = sum_ext[CNT_W] ? {CNT_W{1'b1}} : sum_ext[CNT_W-1:0];
    end
    // Last response lands on the same edge as DONE, so judge the final maximum
    if ((state_q == DRAIN) && (drn_q == '0)) pass_d = (max_d <= et_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dut_in_q  <= '0;
      et_q      <= '0;
      drn_q     <= '0;
      pass_q    <= 1'b0;
      max_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      err_q     <= '0;
      err_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dut_in_q  <= dut_in_d;
      et_q      <= et_d;
      drn_q     <= drn_d;
      pass_q    <= pass_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      err_vld_q <= err_vld_d;
    end
  end

`ifdef APPROX_ERR_TRACE_EN
  logic [IN_W-1:0]  err_vec_q;
  logic [OUT_W-1:0] err_out_q;
  logic             ff_vld_q, ff_vld_d;
  logic [IN_W-1:0]  ff_vec_q, ff_vec_d;
  logic [OUT_W-1:0] ff_out_q, ff_out_d;

  always_comb begin
    ff_vld_d = ff_vld_q;
    ff_vec_d = ff_vec_q;
    ff_out_d = ff_out_q;
    if (accept) begin
      ff_vld_d = 1'b0;
      ff_vec_d = '0;
      ff_out_d = '0;
    end else if (err_vld_q && (err_q > et_q) && !ff_vld_q) begin
      ff_vld_d = 1'b1;
      ff_vec_d = err_vec_q;
      ff_out_d = err_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_vec_q <= '0;
      err_out_q <= '0;
      ff_vld_q  <= 1'b0;
      ff_vec_q  <= '0;
      ff_out_q  <= '0;
    end else begin
      err_vec_q <= dly_vec;
      err_out_q <= dut_out;
      ff_vld_q  <= ff_vld_d;
      ff_vec_q  <= ff_vec_d;
      ff_out_q  <= ff_out_d;
    end
  end

  assign first_fail_vld = ff_vld_q;
  assign first_fail_vec = ff_vec_q;
  assign first_fail_out = ff_out_q;
`endif

  assign dut_in  = dut_in_q;
  assign busy    = (state_q == SWEEP) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign max_err = max_q;
  assign err_cnt = cnt_q;
  assign err_sum = sum_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench for approx_err_monitor: a combinational (DUT_LAT=0) and a registered
// (DUT_LAT=2, CNT_W=4) instance share stimulus; a sweep-level model predicts each result.
`timescale 1ns/1ps
module tb_approx_err_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] et = 2'd0;

  logic [3:0] dut_in0, dut_in2;
  logic [1:0] dut_out0, dut_out2;
  logic       busy0, busy2, done0, done2, pass0, pass2;
  logic [1:0] max_err0, max_err2;
  logic [7:0] err_cnt0, err_sum0;
  logic [3:0] err_cnt2, err_sum2;
`ifdef APPROX_ERR_TRACE_EN
  logic       ffv0, ffv2;
  logic [3:0] ffvec0, ffvec2;
  logic [1:0] ffout0, ffout2;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          mode = 0;
  logic [31:0] lut_p = '0;
  logic [1:0]  p1, p2;

  typedef struct {
    int mx; int cnt; int sum; int pass; int scyc;
    int ffv; int ffvec; int ffout;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behaviour of the device under evaluation: 0 exact, 1 stuck at zero, 2 lookup table
  function automatic logic [1:0] resp(input logic [3:0] v, input int m, input logic [31:0] lp);
    int a, b, d;
    a = int'(v) / 4;
    b = int'(v) % 4;
    d = (a > b) ? a - b : b - a;
    case (m)
      0:       return 2'(d);
      1:       return 2'b00;
      default: return lp[2*v +: 2];
    endcase
  endfunction

  always_comb dut_out0 = resp(dut_in0, mode, lut_p);

  always @(posedge clk) begin
    p1 <= resp(dut_in2, mode, lut_p);
    p2 <= p1;
  end
  assign dut_out2 = p2;

  approx_err_monitor #(.IN_W(4), .OUT_W(2), .DUT_LAT(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .et(et),
    .dut_in(dut_in0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .pass(pass0),
    .max_err(max_err0), .err_cnt(err_cnt0),
`ifdef APPROX_ERR_TRACE_EN
    .first_fail_vld(ffv0), .first_fail_vec(ffvec0), .first_fail_out(ffout0),
`endif
    .err_sum(err_sum0)
  );

  approx_err_monitor #(.IN_W(4), .OUT_W(2), .DUT_LAT(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .et(et),
    .dut_in(dut_in2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .pass(pass2),
    .max_err(max_err2), .err_cnt(err_cnt2),
`ifdef APPROX_ERR_TRACE_EN
    .first_fail_vld(ffv2), .first_fail_vec(ffvec2), .first_fail_out(ffout2),
`endif
    .err_sum(err_sum2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole-sweep model: score every vector, saturate counters at cmax
  function automatic exp_t build(input int cmax, input int et_i, input int scyc);
    exp_t r;
    int a, b, ex, o, e;
    r = '{mx: 0, cnt: 0, sum: 0, pass: 0, scyc: scyc, ffv: 0, ffvec: 0, ffout: 0};
    for (int v = 0; v < 16; v++) begin
      a  = v / 4;
      b  = v % 4;
      ex = ((a > b) ? a - b : b - a) % 4;
      o  = int'(resp(4'(v), mode, lut_p));
      e  = (ex > o) ? ex - o : o - ex;
      if (e > r.mx) r.mx = e;
      if (e != 0) r.cnt++;
      r.sum += e;
      if (e > et_i && r.ffv == 0) begin
        r.ffv = 1; r.ffvec = v; r.ffout = o;
      end
    end
    if (r.cnt > cmax) r.cnt = cmax;
    if (r.sum > cmax) r.sum = cmax;
    r.pass = (r.mx <= et_i) ? 1 : 0;
    return r;
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) begin
        chk("lat0_unexpected_done", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("lat0_latency", cyc - e.scyc, 18);
        chk("lat0_max_err", int'(max_err0), e.mx);
        chk("lat0_err_cnt", int'(err_cnt0), e.cnt);
        chk("lat0_err_sum", int'(err_sum0), e.sum);
        chk("lat0_pass", int'(pass0), e.pass);
        chk("lat0_busy_at_done", int'(busy0), 0);
`ifdef APPROX_ERR_TRACE_EN
        chk("lat0_ff_vld", int'(ffv0), e.ffv);
        if (e.ffv != 0) begin
          chk("lat0_ff_vec", int'(ffvec0), e.ffvec);
          chk("lat0_ff_out", int'(ffout0), e.ffout);
        end
`endif
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) begin
        chk("lat2_unexpected_done", 1, 0);
      end else begin
        e = q2.pop_front();
        chk("lat2_latency", cyc - e.scyc, 20);
        chk("lat2_max_err", int'(max_err2), e.mx);
        chk("lat2_err_cnt", int'(err_cnt2), e.cnt);
        chk("lat2_err_sum", int'(err_sum2), e.sum);
        chk("lat2_pass", int'(pass2), e.pass);
`ifdef APPROX_ERR_TRACE_EN
        chk("lat2_ff_vld", int'(ffv2), e.ffv);
        if (e.ffv != 0) begin
          chk("lat2_ff_vec", int'(ffvec2), e.ffvec);
          chk("lat2_ff_out", int'(ffout2), e.ffout);
        end
`endif
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dut_in0"}, int'(dut_in0), 0);
    chk({tag, "_busy0"}, int'(busy0), 0);
    chk({tag, "_done0"}, int'(done0), 0);
    chk({tag, "_pass0"}, int'(pass0), 0);
    chk({tag, "_max0"}, int'(max_err0), 0);
    chk({tag, "_cnt0"}, int'(err_cnt0), 0);
    chk({tag, "_sum0"}, int'(err_sum0), 0);
    chk({tag, "_dut_in2"}, int'(dut_in2), 0);
    chk({tag, "_busy2"}, int'(busy2), 0);
    chk({tag, "_pass2"}, int'(pass2), 0);
    chk({tag, "_sum2"}, int'(err_sum2), 0);
`ifdef APPROX_ERR_TRACE_EN
    chk({tag, "_ffv0"}, int'(ffv0), 0);
`endif
  endtask

  // One full sweep; optionally a second start pulse mid-sweep that must be ignored
  task automatic do_sweep(input int m, input logic [31:0] lp, input int et_i, input bit extra);
    exp_t e0, e2;
    @(negedge clk);
    mode  = m;
    lut_p = lp;
    et    = 2'(et_i);
    start = 1'b1;
    e0 = build(255, et_i, cyc);
    e2 = build(15, et_i, cyc);
    q0.push_back(e0);
    q2.push_back(e2);
    @(negedge clk);
    start = 1'b0;
    chk("busy0_after_start", int'(busy0), 1);
    chk("dut_in0_first_vec", int'(dut_in0), 0);
    if (extra) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      et    = 2'(~et_i);
      @(negedge clk);
      start = 1'b0;
    end
    repeat (24) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q2_drained", q2.size(), 0);
    if (q0.size() != 0) q0.delete();
    if (q2.size() != 0) q2.delete();
    chk("hold_max0", int'(max_err0), e0.mx);
    chk("hold_pass2", int'(pass2), e2.pass);
    chk("idle_dut_in0", int'(dut_in0), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    do_sweep(0, 32'h0, 0, 1'b0);   // loopback
    do_sweep(1, 32'h0, 1, 1'b0);   // stuck zero, tight threshold
    do_sweep(1, 32'h0, 3, 1'b0);   // stuck zero, loose threshold
    do_sweep(2, $urandom, int'($urandom_range(0, 3)), 1'b1);

    // abort mid-sweep with a coincident start pulse
    @(negedge clk);
    mode  = 1;
    et    = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort");
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("start_in_reset_ignored", int'(busy0), 0);

    do_sweep(1, 32'h0, 1, 1'b0);
    for (int k = 0; k < 6; k++)
      do_sweep(2, $urandom, int'($urandom_range(0, 3)), k[0]);
    do_sweep(0, 32'h0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
